seq_det_ctrl: RTL and testbench

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

---
 rtl/seq_det_ctrl.sv | 111 +++++++++++
 tb/tb_seq_det_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// Serializes words MSB first into an external sequence detector and
// reports per-word match count, hit flag and first-match bit index.
module seq_det_ctrl #(
  parameter  int WIDTH = 8,
  parameter  int CNT_W = 4,
  localparam int IDX_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             abort,
  output logic             det_din,
  output logic             det_rst,
  input  logic             det_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_hit,
  output logic [IDX_W-1:0] out_first
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DRAIN,
    REPORT
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [IDX_W-1:0]   bit_q, bit_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   first_q, first_d;
  logic               samp;
  logic [IDX_W-1:0]   idx;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    samp    = 1'b0;
    idx     = bit_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SHIFT;
          sh_d    = in_data;
          bit_d   = '0;
          cnt_d   = '0;
          first_d = '0;
        end
      end
      SHIFT: begin
        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        bit_d = bit_q + 1'b1;
        // flag in the first cycle still reflects the reset detector
        samp  = det_flag && (bit_q != '0);
        idx   = bit_q;
        if (bit_q == IDX_W'(WIDTH - 1))
          state_d = DRAIN;
      end
      DRAIN: begin
        samp    = det_flag;
        idx     = IDX_W'(WIDTH);
        state_d = REPORT;
      end
      REPORT: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (samp) begin
      if (cnt_q != '1)
        cnt_d = cnt_q + 1'b1;
      if (first_q == '0)
        first_d = idx;
    end
    if (abort && (state_q == SHIFT || state_q == DRAIN))
      state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == REPORT);
  assign det_din   = (state_q == SHIFT) ? sh_q[WIDTH-1] : 1'b1;
  assign det_rst   = rst || (state_q == IDLE) || (state_q == REPORT);
  assign out_count = cnt_q;
  assign out_hit   = (cnt_q != '0);
  assign out_first = first_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl with attached 0101010 detectors: directed
// and random words checked against a window-matching reference.
module tb_seq_det_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   tests = 0;
  int   fails = 0;

  logic       iv8, rd8, ab8, ov8, or8, oh8;
  logic [7:0] id8;
  logic [3:0] oc8, of8;

  logic        iv16, rd16a, rd16b, ab16, ov16a, ov16b, or16;
  logic        oh16a, oh16b;
  logic [15:0] id16;
  logic [3:0]  oc16a;
  logic [1:0]  oc16b;
  logic [4:0]  of16a, of16b;

  logic       din0, din1, din2, rst0, rst1, rst2;
  logic [2:0] ddin, drst, dfl;
  assign ddin = {din2, din1, din0};
  assign drst = {rst2, rst1, rst0};

  seq_det_ctrl #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rd8),
    .in_data(id8), .abort(ab8), .det_din(din0), .det_rst(rst0),
    .det_flag(dfl[0]), .out_valid(ov8), .out_ready(or8),
    .out_count(oc8), .out_hit(oh8), .out_first(of8)
  );

  seq_det_ctrl #(.WIDTH(16), .CNT_W(4)) dut16a (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(rd16a),
    .in_data(id16), .abort(ab16), .det_din(din1), .det_rst(rst1),
    .det_flag(dfl[1]), .out_valid(ov16a), .out_ready(or16),
    .out_count(oc16a), .out_hit(oh16a), .out_first(of16a)
  );

  seq_det_ctrl #(.WIDTH(16), .CNT_W(2)) dut16b (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(rd16b),
    .in_data(id16), .abort(ab16), .det_din(din2), .det_rst(rst2),
    .det_flag(dfl[2]), .out_valid(ov16b), .out_ready(or16),
    .out_count(oc16b), .out_hit(oh16b), .out_first(of16b)
  );

  // overlapping 0101010 detector with registered flag
  logic [5:0] hist [3];
  int         nb   [3];
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (drst[k]) begin
        hist[k] <= '0;
        nb[k]   <= 0;
        dfl[k]  <= 1'b0;
      end else begin
        hist[k] <= {hist[k][4:0], ddin[k]};
        if (nb[k] < 7) nb[k] <= nb[k] + 1;
        dfl[k] <= (nb[k] >= 6) &&
                  ({hist[k], ddin[k]} == 7'b0101010);
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // matches counted by sliding the pattern over the MSB-first bits
  function automatic void model(input logic [15:0] d, input int w,
                                output int cnt, output int first);
    logic [6:0] pat;
    bit         m;
    pat   = 7'b0101010;
    cnt   = 0;
    first = 0;
    for (int i = 7; i <= w; i++) begin
      m = 1'b1;
      for (int k = 0; k < 7; k++)
        if (d[w - (i - 6 + k)] !== pat[6 - k]) m = 1'b0;
      if (m) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
  endfunction

  task automatic chk_idle8(input string tag);
    chk({tag, "_rdy"}, rd8, 1);
    chk({tag, "_ov"}, ov8, 0);
    chk({tag, "_din"}, din0, 1);
    chk({tag, "_drst"}, rst0, 1);
  endtask

  task automatic accept8(input logic [7:0] d);
    @(negedge clk);
    chk("acc_rdy", rd8, 1);
    iv8 = 1'b1;
    id8 = d;
    ab8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    ab8 = 1'b0;
    id8 = 8'($urandom);
  endtask

  task automatic run8(input logic [7:0] d, input int hold);
    int ec, ef;
    model({8'h00, d}, 8, ec, ef);
    accept8(d);
    for (int n = 1; n <= 9; n++) begin
      chk("lat_ov", ov8, 0);
      chk("busy_rdy", rd8, 0);
      if (n <= 8) begin
        chk("din", din0, d[8 - n]);
        chk("drst_act", rst0, 0);
      end
      @(negedge clk);
    end
    or8 = 1'b0;
    ab8 = 1'b1;
    for (int h = 0; h <= hold; h++) begin
      chk("rep_ov", ov8, 1);
      chk("rep_rdy", rd8, 0);
      chk("count", oc8, ec);
      chk("hit", oh8, ec != 0);
      chk("first", of8, ef);
      chk("rep_din", din0, 1);
      if (h < hold) @(negedge clk);
    end
    ab8 = 1'b0;
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    chk_idle8("post");
  endtask

  task automatic abort8(input logic [7:0] d, input int at);
    accept8(d);
    repeat (at - 1) @(negedge clk);
    ab8 = 1'b1;
    @(negedge clk);
    ab8 = 1'b0;
    chk_idle8("abort");
    repeat (12) begin
      @(negedge clk);
      chk("abort_noov", ov8, 0);
    end
  endtask

  task automatic run16(input logic [15:0] d);
    int ec, ef;
    model(d, 16, ec, ef);
    @(negedge clk);
    iv16 = 1'b1;
    id16 = d;
    @(negedge clk);
    iv16 = 1'b0;
    id16 = 16'($urandom);
    for (int n = 1; n <= 17; n++) begin
      chk("lat16_ov", ov16a | ov16b, 0);
      @(negedge clk);
    end
    chk("ov16a", ov16a, 1);
    chk("ov16b", ov16b, 1);
    chk("count16", oc16a, ec);
    chk("count16_sat", oc16b, (ec > 3) ? 3 : ec);
    chk("hit16", oh16b, ec != 0);
    chk("first16a", of16a, ef);
    chk("first16b", of16b, ef);
    or16 = 1'b1;
    @(negedge clk);
    or16 = 1'b0;
    chk("post16_rdy", rd16a & rd16b, 1);
  endtask

  task automatic chk_reset8(input string tag);
    chk_idle8(tag);
    chk({tag, "_cnt"}, oc8, 0);
    chk({tag, "_hit"}, oh8, 0);
    chk({tag, "_first"}, of8, 0);
  endtask

  initial begin
    rst  = 1'b1;
    iv8  = 1'b0; id8  = '0; ab8  = 1'b0; or8  = 1'b0;
    iv16 = 1'b0; id16 = '0; ab16 = 1'b0; or16 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_drst", rst0, 1);
    rst = 1'b0;
    @(negedge clk);
    chk_reset8("reset");

    run8(8'b0101_0100, 0);
    run8(8'hFF, 5);
    run8(8'h55, 2);
    run16(16'h5555);

    abort8(8'b0101_0100, 4);
    abort8(8'b0101_0100, 9);
    run8(8'b0101_0100, 1);

    // reset while reporting
    accept8(8'b0101_0100);
    repeat (9) @(negedge clk);
    chk("rr_ov", ov8, 1);
    chk("rr_cnt", oc8, 1);
    rst = 1'b1;
    #1;
    chk("rr_drst", rst0, 1);
    @(negedge clk);
    rst = 1'b0;
    chk_reset8("rst_rep");

    // reset mid-word
    accept8(8'hAA);
    repeat (4) @(negedge clk);
    chk("rs_drst0", rst0, 0);
    rst = 1'b1;
    #1;
    chk("rs_drst", rst0, 1);
    @(negedge clk);
    rst = 1'b0;
    chk_reset8("rst_shift");
    repeat (12) begin
      @(negedge clk);
      chk("rs_noov", ov8, 0);
    end

    for (int i = 0; i < 20; i++)
      run8(8'($urandom), int'($urandom_range(0, 3)));
    for (int i = 0; i < 6; i++)
      run16(16'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
